// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//
// Instruction-fetch stage for the 16-bit pipeline. Owns the PC, keeps at most
// one request outstanding to a variable-latency instruction memory, and holds
// each fetched instruction (with its PC and PC+2) until the downstream stage
// consumes it. Applies stall, redirect and halt control.
//
// Ports:
//   clk          clock
//   rst          asynchronous active-high reset
//   stall        downstream hazard stall; the held instruction is not consumed
//   redirect_en  taken branch/jump resolved; flush and refetch
//   redirect_pc  redirect target (bit 0 ignored)
//   imem_req     one-cycle read request strobe
//   imem_addr    request address
//   imem_rdata   returned instruction
//   imem_valid   imem_rdata valid (at least one cycle after imem_req)
//   instr_out    held instruction, NOP_INSTR when !fetch_valid
//   curr_pc_out  PC of instr_out
//   next_pc_out  curr_pc_out + 2
//   fetch_valid  instr_out holds a real instruction
//   halted       fetch stopped on a HALT instruction
// -----------------------------------------------------------------------------
module fetch_stage #(
  parameter logic [15:0] RESET_PC    = 16'h0000,
  parameter logic [15:0] NOP_INSTR   = 16'b00001_00000000000,
  parameter logic [4:0]  HALT_OPCODE = 5'b00000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect_en,
  input  logic [15:0] redirect_pc,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_rdata,
  input  logic        imem_valid,
  output logic [15:0] instr_out,
  output logic [15:0] curr_pc_out,
  output logic [15:0] next_pc_out,
  output logic        fetch_valid,
  output logic        halted
);

  typedef enum logic [2:0] {
    ISSUE,
    WAIT,
    HOLD,
    DRAIN,
    HALTED
  } fetchState_t;

  fetchState_t state;
  fetchState_t nextState;

  logic [15:0] pc;
  logic [15:0] pcPlus2;
  logic [15:0] redirectTarget;
  logic [15:0] instrReg;
  logic [15:0] currPcReg;
  logic [15:0] nextPcReg;
  logic        fetchValidReg;
  logic        haltedReg;

  logic        reqComb;
  logic [15:0] addrComb;
  logic        isHalt;
  logic        outstanding;

  assign pcPlus2        = pc + 16'd2;  // wraps 16'hFFFE -> 16'h0000
  assign redirectTarget = {redirect_pc[15:1], 1'b0};
  assign isHalt         = (instrReg[15:11] == HALT_OPCODE);
  assign outstanding    = (state == WAIT) || (state == DRAIN);

  // Next-state and request strobe. The request is Mealy in HOLD so that a
  // consume issues the following fetch in the same cycle (one instruction per
  // two cycles at single-cycle memory latency).
  always_comb begin
    // NOTE: every variable gets a default before any branch; a path that
    // leaves one unassigned would infer a latch.
    nextState = state;
    reqComb   = 1'b0;
    addrComb  = pc;

    if (redirect_en) begin
      // A request still in flight must be drained before a new one is issued,
      // so DRAIN also re-enters DRAIN when its response has not yet arrived.
      // A request strobe here would leave two requests outstanding, so none
      // is raised.
      if (outstanding && !imem_valid) nextState = DRAIN;
      else                            nextState = ISSUE;
    end else begin
      unique case (state)
        ISSUE: begin
          reqComb   = 1'b1;
          nextState = WAIT;
        end
        WAIT: begin
          if (imem_valid) nextState = HOLD;
        end
        HOLD: begin
          if (!stall) begin
            if (isHalt) begin
              nextState = HALTED;
            end else begin
              reqComb   = 1'b1;
              addrComb  = pcPlus2;
              nextState = WAIT;
            end
          end
        end
        DRAIN: begin
          if (imem_valid) nextState = ISSUE;
        end
        HALTED: nextState = HALTED;
        default: nextState = ISSUE;
      endcase
    end
  end

  // Reset forces the strobe low immediately, before the first clock edge.
  assign imem_req  = reqComb & ~rst;
  assign imem_addr = addrComb;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ISSUE;
      pc            <= RESET_PC;
      instrReg      <= NOP_INSTR;
      currPcReg     <= 16'h0000;
      nextPcReg     <= 16'h0000;
      fetchValidReg <= 1'b0;
      haltedReg     <= 1'b0;
    end else begin
      state <= nextState;
      if (redirect_en) begin
        pc            <= redirectTarget;
        instrReg      <= NOP_INSTR;
        fetchValidReg <= 1'b0;
        haltedReg     <= 1'b0;
      end else begin
        unique case (state)
          WAIT: begin
            if (imem_valid) begin
              instrReg      <= imem_rdata;
              currPcReg     <= pc;
              nextPcReg     <= pcPlus2;
              fetchValidReg <= 1'b1;
            end
          end
          HOLD: begin
            if (!stall) begin
              pc            <= pcPlus2;
              instrReg      <= NOP_INSTR;
              fetchValidReg <= 1'b0;
              if (isHalt) haltedReg <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign instr_out   = instrReg;
  assign curr_pc_out = currPcReg;
  assign next_pc_out = nextPcReg;
  assign fetch_valid = fetchValidReg;
  assign halted      = haltedReg;

endmodule
